// File: rtl/incrementador_pontos.sv
// incrementador_pontos
// BCD score accumulator. Each accepted add request puts a 0-9 amount into the
// score one digit per clock, rippling the carry upward, so no wide BCD adder
// is needed. A one-cycle extra-life pulse is raised when the add carries into
// digit BONUS_DIG. The score saturates at all-9s.
//
// Ports:
//   clock       system clock, all state changes on the rising edge
//   clr         asynchronous active-high reset
//   zera        synchronous score clear; beats everything except clr
//   inc         add request, taken only while pronto=1
//   valor       BCD amount to add; values above 9 count as 9
//   Q           BCD score, digit i at Q[4i+3:4i]; valid while pronto=1
//   pronto      idle and ready to accept inc
//   sat         score is stuck at all-9s
//   vida_extra  one-cycle extra-life pulse
module incrementador_pontos #(
   parameter int DIGITS    = 4,
   parameter int BONUS_DIG = 3
) (
   input  logic                  clock,
   input  logic                  clr,
   input  logic                  zera,
   input  logic                  inc,
   input  logic [3:0]            valor,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  pronto,
   output logic                  sat,
   output logic                  vida_extra
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0]       I_LAST    = IW'(DIGITS - 1);
   localparam logic [IW-1:0]       I_BONUS   = IW'(BONUS_DIG - 1);
   localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SOMA = 2'd1,
      FIM  = 2'd2
   } estado_t;

   // Amounts above 9 are not valid BCD; treat them as the largest digit.
   function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
      if (v > 4'd9) begin
         clamp_bcd = 4'd9;
      end else begin
         clamp_bcd = v;
      end
   endfunction

   estado_t             state_r, state_s;
   logic [4*DIGITS-1:0] q_r, q_s;
   logic [3:0]          c_r, c_s;     // amount still to add into digit i
   logic [IW-1:0]       i_r, i_s;     // digit being processed
   logic                b_r, b_s;     // carry reached the bonus digit
   logic                sat_r, sat_s;
   logic [3:0]          digit_s;
   logic [4:0]          sum_s;

   // Outputs come straight from the state registers.
   assign Q          = q_r;
   assign sat        = sat_r;
   assign pronto     = (state_r == IDLE);
   // c still set in FIM means the top digit overflowed: no bonus on that add.
   assign vida_extra = (state_r == FIM) && b_r && (c_r == 4'd0);

   // Next-state and datapath update for the digit-serial add.
   always_comb begin
      state_s = state_r;
      q_s     = q_r;
      c_s     = c_r;
      i_s     = i_r;
      b_s     = b_r;
      sat_s   = sat_r;
      digit_s = q_r[4*i_r +: 4];
      sum_s   = {1'b0, digit_s} + {1'b0, c_r};

      if (zera) begin
         state_s = IDLE;
         q_s     = '0;
         c_s     = 4'd0;
         i_s     = '0;
         b_s     = 1'b0;
         sat_s   = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (inc && !sat_r) begin
                  c_s     = clamp_bcd(valor);
                  i_s     = '0;
                  b_s     = 1'b0;
                  state_s = SOMA;
               end else begin
                  state_s = IDLE;
               end
            end
            SOMA: begin
               if (sum_s > 5'd9) begin
                  // Sum is 10..18, so the low nibble minus 10 wraps to the right digit.
                  q_s[4*i_r +: 4] = sum_s[3:0] - 4'd10;
                  c_s             = 4'd1;
                  if (i_r == I_BONUS) begin
                     b_s = 1'b1;
                  end else begin
                     b_s = b_r;
                  end
               end else begin
                  q_s[4*i_r +: 4] = sum_s[3:0];
                  c_s             = 4'd0;
               end
               if ((c_s == 4'd0) || (i_r == I_LAST)) begin
                  state_s = FIM;
               end else begin
                  i_s = i_r + IW'(1);
               end
            end
            FIM: begin
               // Carry left over here came out of the top digit.
               if (c_r != 4'd0) begin
                  q_s   = ALL_NINES;
                  sat_s = 1'b1;
                  b_s   = 1'b0;
               end else begin
                  q_s = q_r;
               end
               c_s     = 4'd0;
               state_s = IDLE;
            end
            default: begin
               state_s = IDLE;
               c_s     = 4'd0;
               b_s     = 1'b0;
            end
         endcase
      end
   end

   // State register with asynchronous clear.
   always_ff @(posedge clock or posedge clr) begin
      if (clr) begin
         state_r <= IDLE;
         q_r     <= '0;
         c_r     <= 4'd0;
         i_r     <= '0;
         b_r     <= 1'b0;
         sat_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         q_r     <= q_s;
         c_r     <= c_s;
         i_r     <= i_s;
         b_r     <= b_s;
         sat_r   <= sat_s;
      end
   end

endmodule

// File: tb/tb_incrementador_pontos.sv
module tb_incrementador_pontos;

   localparam int DIGITS    = 4;
   localparam int BONUS_DIG = 3;
   localparam int MAXV      = 9999;
   localparam int BONUSP    = 1000;

   logic                clock;
   logic                clr;
   logic                zera;
   logic                inc;
   logic [3:0]          valor;
   logic [4*DIGITS-1:0] q;
   logic                pronto;
   logic                sat;
   logic                vida_extra;

   int checks   = 0;
   int failures = 0;
   int m_score  = 0;
   bit m_sat    = 1'b0;

   incrementador_pontos #(.DIGITS(DIGITS), .BONUS_DIG(BONUS_DIG)) dut (
      .clock(clock), .clr(clr), .zera(zera), .inc(inc), .valor(valor),
      .Q(q), .pronto(pronto), .sat(sat), .vida_extra(vida_extra)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [3:0]  v;
      logic [15:0] q;
      int          low;
      int          pul;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      int x;
      r = '0;
      x = n;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one add and measure how long pronto stays low and how many bonus pulses appear.
   task automatic do_add(input logic [3:0] v, output int lowc, output int pulses);
      inc   = 1'b1;
      valor = v;
      tick();
      inc   = 1'b0;
      lowc  = 0;
      pulses = 0;
      while (!pronto && lowc < 100) begin
         if (vida_extra) pulses++;
         lowc++;
         tick();
      end
      if (lowc >= 100) begin
         failures++;
         checks++;
         $display("FAIL timeout: pronto never returned (got low=%0d expected <100)", lowc);
      end
   endtask

   // Reference: score as an integer, digit activity derived from modular arithmetic.
   task automatic check_add(input logic [3:0] v);
      int vv, nw, k, p, lowc, pulses, exp_low, exp_pul;
      vv = (v > 9) ? 9 : int'(v);
      if (m_sat) begin
         exp_low = 0;
         exp_pul = 0;
      end else begin
         nw = m_score + vv;
         k = 1;
         p = 10;
         for (int j = 0; j < DIGITS - 1; j++) begin
            if ((m_score % p) + vv >= p) begin
               k++;
               p = p * 10;
            end else begin
               break;
            end
         end
         exp_low = k + 1;
         if (nw > MAXV) begin
            m_score = MAXV;
            m_sat   = 1'b1;
            exp_pul = 0;
         end else begin
            exp_pul = ((nw / BONUSP) != (m_score / BONUSP)) ? 1 : 0;
            m_score = nw;
         end
      end
      do_add(v, lowc, pulses);
      chk("add_q", 32'(q), 32'(to_bcd(m_score)));
      chk("add_sat", 32'(sat), 32'(m_sat));
      chk("add_latency", lowc, exp_low);
      chk("add_bonus", pulses, exp_pul);
   endtask

   task automatic reach(input int target);
      while (m_score < target && !m_sat) begin
         check_add(4'((target - m_score) > 9 ? 9 : (target - m_score)));
      end
   endtask

   task automatic pulse_zera();
      zera = 1'b1;
      tick();
      zera = 1'b0;
      m_score = 0;
      m_sat   = 1'b0;
   endtask

   initial begin
      int lowc, pulses, seen;
      clr = 1'b0; zera = 1'b0; inc = 1'b0; valor = 4'd0;

      // Asynchronous reset before any clock edge.
      #2 clr = 1'b1;
      #1;
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_pronto", 32'(pronto), 32'h1);
      chk("rst_sat", 32'(sat), 32'h0);
      chk("rst_vida", 32'(vida_extra), 32'h0);
      tick();
      clr = 1'b0;
      for (int n = 0; n < 10; n++) tick();
      chk("idle_q", 32'(q), 32'h0);
      chk("idle_pronto", 32'(pronto), 32'h1);

      // Table of adds starting from zero.
      tbl[0] = '{4'd8,  16'h0008, 2, 0};
      tbl[1] = '{4'd5,  16'h0013, 3, 0};
      tbl[2] = '{4'hC,  16'h0022, 3, 0};
      tbl[3] = '{4'd0,  16'h0022, 2, 0};
      tbl[4] = '{4'd9,  16'h0031, 3, 0};
      tbl[5] = '{4'hF,  16'h0040, 3, 0};
      for (int n = 0; n < 6; n++) begin
         do_add(tbl[n].v, lowc, pulses);
         chk("tbl_q", 32'(q), 32'(tbl[n].q));
         chk("tbl_low", lowc, tbl[n].low);
         chk("tbl_bonus", pulses, tbl[n].pul);
      end
      m_score = 40;

      // Bonus crossing 0995 + 7 -> 1002, then 1002 + 9 -> 1011.
      reach(995);
      do_add(4'd7, lowc, pulses);
      chk("bonus_q", 32'(q), 32'h1002);
      chk("bonus_low", lowc, 5);
      chk("bonus_pulse", pulses, 1);
      do_add(4'd9, lowc, pulses);
      chk("post_bonus_q", 32'(q), 32'h1011);
      chk("post_bonus_pulse", pulses, 0);
      m_score = 1011;

      // Saturation 9998 + 5.
      reach(9998);
      do_add(4'd5, lowc, pulses);
      chk("sat_q", 32'(q), 32'h9999);
      chk("sat_flag", 32'(sat), 32'h1);
      chk("sat_low", lowc, 5);
      chk("sat_pulse", pulses, 0);
      m_score = MAXV; m_sat = 1'b1;
      check_add(4'd3);
      pulse_zera();
      chk("zera_q", 32'(q), 32'h0);
      chk("zera_sat", 32'(sat), 32'h0);

      // inc held high across the whole busy period: only one add.
      inc = 1'b1; valor = 4'd2;
      tick(); tick(); tick();
      inc = 1'b0;
      tick();
      chk("busy_q", 32'(q), 32'h0002);
      chk("busy_pronto", 32'(pronto), 32'h1);
      m_score = 2;
      check_add(4'hC);

      // Abort with zera on the second SOMA cycle.
      pulse_zera();
      reach(999);
      inc = 1'b1; valor = 4'd1; seen = 0;
      tick();
      inc = 1'b0;
      if (vida_extra) seen++;
      tick();
      zera = 1'b1;
      if (vida_extra) seen++;
      tick();
      zera = 1'b0;
      chk("abort_q", 32'(q), 32'h0);
      chk("abort_pronto", 32'(pronto), 32'h1);
      for (int n = 0; n < 4; n++) begin
         if (vida_extra) seen++;
         tick();
      end
      chk("abort_vida", seen, 0);
      m_score = 0; m_sat = 1'b0;

      // Same abort using clr.
      reach(999);
      inc = 1'b1; valor = 4'd1; seen = 0;
      tick();
      inc = 1'b0;
      tick();
      clr = 1'b1;
      #1;
      chk("clr_abort_q", 32'(q), 32'h0);
      chk("clr_abort_pronto", 32'(pronto), 32'h1);
      tick();
      clr = 1'b0;
      for (int n = 0; n < 4; n++) begin
         if (vida_extra) seen++;
         tick();
      end
      chk("clr_abort_vida", seen, 0);
      chk("clr_abort_q2", 32'(q), 32'h0);
      m_score = 0; m_sat = 1'b0;

      // Random adds from zero, with occasional clears.
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 24) == 0) begin
            pulse_zera();
            chk("rnd_zera_q", 32'(q), 32'h0);
         end else begin
            check_add(4'($urandom_range(0, 15)));
         end
      end

      // Random adds near the top, running into saturation.
      pulse_zera();
      reach(9950);
      for (int n = 0; n < 40; n++) begin
         check_add(4'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
